keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//  Column-scan sequencer for the 4x4 Pmod keypad on the shared 8-bit inout header.
//  Drives one column low at a time and samples the rows; debounces a single press
//  and emits a one-cycle key_valid with a 4-bit hex code.
//  Blocks until release before the next press, so downstream digit-capture logic
//  sees exactly one pulse per press.
// PARAMETERS
//  CLK_FREQ       50_000_000  system clock in Hz
//  DEBOUNCE_MS    1           press/release stable time in ms; DB_CYC = CLK_FREQ/1000*DEBOUNCE_MS
//  SETTLE_CYCLES  8           cycles between column change and first row sample (>=1)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  synchronous, active-high reset
//  en         in   1  scan enable; low parks the controller
//  row_n      in   4  keypad rows, active-low, asynchronous to clk
//  col_n      out  4  column drive, one-cold; 4'b1111 = none driven
//  key_code   out  4  hex code of last accepted key; held until next accept
//  key_valid  out  1  one-cycle pulse; key_code is valid in the same cycle
//  key_held   out  1  high from the key_valid cycle until release is debounced
// BEHAVIOUR
//  - Reset values: col_n=4'b1111, key_code=0, key_valid=0, key_held=0; state=IDLE, col_idx=0, counters=0.
//  - row_n passes through a 2-flop synchronizer (rows_s); all decisions use rows_s.
//  - States and transitions:
//    IDLE    col_n=1111. Go to SETTLE with col_idx=0 when en=1.
//    SETTLE  col_n drives col_idx low. Count SETTLE_CYCLES+2 cycles (the +2 covers the sync), then SAMPLE.
//    SAMPLE  One cycle. If rows_s==1111, col_idx++ (mod 4, 3->0 wraps) and go to SETTLE.
//            If exactly one row is low, latch pattern and go to DEBOUNCE.
//            If more than one row is low (ghost/multi-press), treat as no key: advance column.
//    DEBOUNCE  Column held. rows_s must equal the latched pattern for DB_CYC consecutive cycles.
//            Any mismatch: discard, col_idx++, go to SETTLE.
//            On reaching DB_CYC: key_code<=KEYMAP[row][col_idx] and key_valid=1 for 1 cycle, key_held<=1, go to RELEASE.
//    RELEASE Column held. Needs rows_s==1111 for DB_CYC consecutive cycles; any low row restarts the count.
//            Then key_held<=0, col_idx++, go to SETTLE.
//  - Scan period with no key pressed: 4*(SETTLE_CYCLES+3) cycles.
//  - Latency: press stable at pins -> key_valid <= scan period + SETTLE_CYCLES+3+DB_CYC cycles.
//  - Holding a key gives exactly one key_valid. A second key pressed during RELEASE is ignored
//    until all rows have been high for DB_CYC cycles.
//  - en=0 in any state: next cycle state=IDLE, col_n=1111, key_held=0, no key_valid. key_code is kept.
//  - rst asserted mid-operation: all outputs return to reset values on the next edge. No partial pulse.
//  - key_valid and en falling in the same cycle: the pulse is still emitted, then IDLE.
//  - Counters are sized $clog2(max count)+1 and saturate, never wrap.
// STRUCTURE
//  - keypad_pkg holds: typedef enum logic [2:0] {IDLE,SETTLE,SAMPLE,DEBOUNCE,RELEASE} kp_state_t;
//    and localparam logic [3:0] KEYMAP[4][4] (row-major, col 0 leftmost):
//      row0: 1 2 3 A
//      row1: 4 5 6 B
//      row2: 7 8 9 C
//      row3: 0 F E D
//    plus a function onehot0_idx() returning the row index and a single-low flag.
//  - One sub-module, sync_2ff #(W=4): reset value 4'b1111.
//  - FSM, column index and counters stay in keypad_scan_ctrl.
// TESTING (bench params: CLK_FREQ=4000, DEBOUNCE_MS=1 -> DB_CYC=4, SETTLE_CYCLES=2)
//  1. Reset, en=1, no key -> col_n cycles 1110,1101,1011,0111,1110 every 5 cycles; key_valid never high.
//  2. Model: pull row 1 low when col 2 is driven, stable 20 cycles -> one key_valid with key_code=4'h6, key_held=1.
//     Then release -> key_held=0 after 4 high cycles and scanning resumes at col 3.
//  3. Row 3 / col 0 with a 2-cycle bounce at press -> first attempt discarded.
//     Next scan pass accepts: exactly one key_valid, key_code=4'h0.
//  4. Rows 0 and 2 low together on col 1 -> no key_valid; col_n keeps advancing.
//  5. Hold key '5' for 100 cycles, press 'D' during RELEASE -> one pulse (5).
//     'D' is accepted only after '5' and 'D' are both released and 'D' is pressed again.
//  6. rst pulse in DEBOUNCE, and separately en=0 in RELEASE -> next edge col_n=1111, key_held=0, no key_valid.
//     key_code=0 after rst; key_code unchanged after en=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state type, key map and row decode helper for the keypad scanner
package keypad_pkg;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, DEBOUNCE, RELEASE} kp_state_t;

    // Row-major, column 0 is the leftmost column of the keypad.
    localparam logic [3:0] KEYMAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    typedef struct packed {
        logic       single;
        logic [1:0] idx;
    } row_hit_t;

    // Rows are active-low: single is set only when exactly one bit is 0.
    function automatic row_hit_t onehot0_idx(input logic [3:0] rows);
        row_hit_t hit;
        int       lows;
        hit  = '0;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) begin
                hit.idx = 2'(i);
                lows++;
            end
        end
        hit.single = (lows == 1);
        return hit;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all-ones (idle rows)
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad column scanner with press/release debounce
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int DEBOUNCE_MS   = 1,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DB_CYC     = CLK_FREQ / 1000 * DEBOUNCE_MS;
    localparam int SETTLE_LEN = SETTLE_CYCLES + 2;
    localparam int CNT_MAX    = (DB_CYC > SETTLE_LEN) ? DB_CYC : SETTLE_LEN;
    localparam int CNT_W      = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_LEN - 1);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DB_CYC - 1);

    kp_state_t        state_q, state_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       pat_q, pat_d;
    logic [1:0]       row_q, row_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       rows_s;
    row_hit_t         hit;

    sync_2ff #(.W(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (row_n),
        .q   (rows_s)
    );

    assign hit     = onehot0_idx(rows_s);
    assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            col_idx_q   <= '0;
            cnt_q       <= '0;
            pat_q       <= 4'hF;
            row_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            row_q       <= row_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        cnt_d       = cnt_inc;
        pat_d       = pat_q;
        row_d       = row_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = SETTLE;
                    col_idx_d = '0;
                    cnt_d     = '0;
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end
                end
                SAMPLE: begin
                    cnt_d = '0;
                    // No key and ghosted multi-press both just move on.
                    if (hit.single) begin
                        state_d = DEBOUNCE;
                        pat_d   = rows_s;
                        row_d   = hit.idx;
                    end else begin
                        state_d   = SETTLE;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != pat_q) begin
                        state_d   = SETTLE;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d     = RELEASE;
                        key_code_d  = KEYMAP[row_q][col_idx_q];
                        key_valid_d = 1'b1;
                        cnt_d       = '0;
                    end
                end
                RELEASE: begin
                    if (rows_s != 4'hF) begin
                        cnt_d = '0;
                    end else if (cnt_q == DB_LAST) begin
                        state_d   = SETTLE;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        col_n = 4'b1111;
        if (state_q != IDLE) begin
            col_n[col_idx_q] = 1'b0;
        end
        key_held  = (state_q == RELEASE);
        key_valid = key_valid_q;
        key_code  = key_code_q;
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - randomized keypad bench with a behavioural scan model
module tb_keypad_scan_ctrl;

    localparam int CLK_FREQ      = 4000;
    localparam int DEBOUNCE_MS   = 1;
    localparam int SETTLE_CYCLES = 2;
    localparam int DB_CYC        = CLK_FREQ / 1000 * DEBOUNCE_MS;

    localparam int M_OFF  = 0;
    localparam int M_SCAN = 1;
    localparam int M_DEB  = 2;
    localparam int M_REL  = 3;

    localparam logic [3:0] KM [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'h0, 4'hF, 4'hE, 4'hD
    };

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;
    logic [3:0]  bounce;

    int vectors;
    int miscompares;
    int cyc;

    int         m_mode;
    int         m_col;
    int         m_t;
    int         m_cnt;
    logic [3:0] m_pat;
    logic [3:0] m_code;
    logic       m_valid;
    logic [3:0] h1;
    logic [3:0] h2;

    keypad_scan_ctrl #(
        .CLK_FREQ      (CLK_FREQ),
        .DEBOUNCE_MS   (DEBOUNCE_MS),
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
        row_n = row_n | bounce;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Outputs are compared against the model state for the previous edge, then
    // the model advances using the inputs the DUT sees at the coming edge.
    task automatic compare_loop();
        logic [3:0] r2;
        logic [3:0] e_col;
        int         row;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                e_col = (m_mode == M_OFF) ? 4'hF : ~(4'b0001 << m_col);
                check("col_n", 32'(col_n), 32'(e_col));
                check("key_valid", 32'(key_valid), 32'(m_valid));
                check("key_code", 32'(key_code), 32'(m_code));
                check("key_held", 32'(key_held), 32'(m_mode == M_REL));
            end
            cyc++;
            r2 = h2;
            if (rst) begin
                m_mode  = M_OFF;
                m_valid = 1'b0;
                m_code  = 4'h0;
                m_col   = 0;
                m_t     = 0;
                m_cnt   = 0;
                h2      = 4'hF;
                h1      = 4'hF;
            end else begin
                m_valid = 1'b0;
                if (!en) begin
                    m_mode = M_OFF;
                end else begin
                    case (m_mode)
                        M_OFF: begin
                            m_mode = M_SCAN;
                            m_col  = 0;
                            m_t    = 0;
                        end
                        M_SCAN: begin
                            if (m_t < SETTLE_CYCLES + 2) begin
                                m_t++;
                            end else if ($countones(~r2) == 1) begin
                                m_mode = M_DEB;
                                m_pat  = r2;
                                m_cnt  = 0;
                            end else begin
                                m_col = (m_col + 1) % 4;
                                m_t   = 0;
                            end
                        end
                        M_DEB: begin
                            if (r2 !== m_pat) begin
                                m_mode = M_SCAN;
                                m_col  = (m_col + 1) % 4;
                                m_t    = 0;
                            end else begin
                                m_cnt++;
                                if (m_cnt == DB_CYC) begin
                                    row = 0;
                                    for (int i = 0; i < 4; i++) if (!m_pat[i]) row = i;
                                    m_code  = KM[row*4 + m_col];
                                    m_valid = 1'b1;
                                    m_mode  = M_REL;
                                    m_cnt   = 0;
                                end
                            end
                        end
                        default: begin
                            if (r2 == 4'hF) m_cnt++;
                            else m_cnt = 0;
                            if (m_cnt == DB_CYC) begin
                                m_mode = M_SCAN;
                                m_col  = (m_col + 1) % 4;
                                m_t    = 0;
                            end
                        end
                    endcase
                end
                h2 = h1;
                h1 = row_n;
            end
        end
    endtask

    task automatic wait_pulse(input int maxc, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < maxc) begin
            step(1);
            waited++;
            if (key_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_release(input int maxc, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < maxc) begin
            step(1);
            waited++;
            if (key_held === 1'b0) ok = 1'b1;
        end
    endtask

    task automatic run(input int n, output int pulses, output int changes);
        logic [3:0] prev;
        pulses = 0;
        changes = 0;
        prev = col_n;
        repeat (n) begin
            step(1);
            if (key_valid === 1'b1) pulses++;
            if (col_n !== prev) changes++;
            prev = col_n;
        end
    endtask

    task automatic wait_mode(input int mode, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            step(1);
            if (m_mode == mode) ok = 1'b1;
        end
    endtask

    initial begin
        bit         ok;
        int         waited;
        int         pulses;
        int         changes;
        logic [3:0] prev;

        vectors = 0; miscompares = 0; cyc = 0;
        m_mode = M_OFF; m_col = 0; m_t = 0; m_cnt = 0;
        m_pat = 4'hF; m_code = 4'h0; m_valid = 1'b0; h1 = 4'hF; h2 = 4'hF;
        rst = 1'b1; en = 1'b0; pressed = '0; bounce = '0;
        fork
            compare_loop();
        join_none

        step(3);
        check("rst_col_n", 32'(col_n), 32'h0000000F);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_held", 32'(key_held), 32'h0);
        rst = 1'b0;
        step(2);

        // Idle scan: one column every SETTLE_CYCLES+3 cycles.
        en = 1'b1;
        pulses = 0;
        for (int k = 0; k < 21; k++) begin
            logic [3:0] exp_col;
            step(1);
            exp_col = ~(4'b0001 << ((k / 5) % 4));
            check("scan_col_n", 32'(col_n), 32'(exp_col));
            if (key_valid === 1'b1) pulses++;
        end
        check("scan_no_pulse", 32'(pulses), 32'h0);

        // Key 6: row 1, column 2.
        pressed[1*4+2] = 1'b1;
        wait_pulse(60, ok, waited);
        check("k6_wait", 32'(ok), 32'h1);
        check("k6_code", 32'(key_code), 32'h6);
        check("k6_held", 32'(key_held), 32'h1);
        run(20, pulses, changes);
        check("k6_single_pulse", 32'(pulses), 32'h0);
        pressed = '0;
        wait_release(20, ok, waited);
        check("k6_release_cycles", 32'(waited), 32'd6);
        check("k6_resume_col3", 32'(col_n), 32'h7);

        // Key 0 with a bounce inside the first debounce window.
        ok = 1'b0;
        prev = col_n;
        for (int i = 0; i < 40 && !ok; i++) begin
            step(1);
            if (col_n == 4'b1110 && prev != 4'b1110) ok = 1'b1;
            prev = col_n;
        end
        check("k0_col0_found", 32'(ok), 32'h1);
        pressed[3*4+0] = 1'b1;
        step(4);
        bounce = 4'b1000;
        step(2);
        bounce = 4'b0000;
        wait_pulse(60, ok, waited);
        check("k0_wait", 32'(ok), 32'h1);
        check("k0_first_discarded", 32'(waited > 10), 32'h1);
        check("k0_code", 32'(key_code), 32'h0);
        run(10, pulses, changes);
        check("k0_single_pulse", 32'(pulses), 32'h0);
        pressed = '0;
        wait_release(20, ok, waited);
        check("k0_release", 32'(ok), 32'h1);

        // Ghost: rows 0 and 2 on column 1.
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        run(40, pulses, changes);
        check("ghost_no_pulse", 32'(pulses), 32'h0);
        check("ghost_advancing", 32'(changes >= 6), 32'h1);
        pressed = '0;
        step(5);

        // Hold 5, press D during release, both released, then D again.
        pressed[1*4+1] = 1'b1;
        wait_pulse(60, ok, waited);
        check("k5_wait", 32'(ok), 32'h1);
        check("k5_code", 32'(key_code), 32'h5);
        run(30, pulses, changes);
        pressed[3*4+3] = 1'b1;
        run(70, waited, changes);
        check("k5_one_pulse", 32'(pulses + waited), 32'h0);
        check("k5_still_held", 32'(key_held), 32'h1);
        pressed = '0;
        wait_release(20, ok, waited);
        check("k5_release", 32'(ok), 32'h1);
        run(30, pulses, changes);
        check("kd_not_yet", 32'(pulses), 32'h0);
        pressed[3*4+3] = 1'b1;
        wait_pulse(60, ok, waited);
        check("kd_wait", 32'(ok), 32'h1);
        check("kd_code", 32'(key_code), 32'hD);
        pressed = '0;
        wait_release(20, ok, waited);

        // Reset while debouncing key 9.
        pressed[2*4+2] = 1'b1;
        wait_mode(M_DEB, 60, ok);
        check("k9_deb_reached", 32'(ok), 32'h1);
        rst = 1'b1;
        step(1);
        check("rst_deb_col_n", 32'(col_n), 32'hF);
        check("rst_deb_held", 32'(key_held), 32'h0);
        check("rst_deb_valid", 32'(key_valid), 32'h0);
        check("rst_deb_code", 32'(key_code), 32'h0);
        rst = 1'b0;
        pressed = '0;
        step(10);

        // Scan disabled while in release of key 9.
        pressed[2*4+2] = 1'b1;
        wait_mode(M_REL, 80, ok);
        check("k9_rel_reached", 32'(ok), 32'h1);
        step(2);
        en = 1'b0;
        step(1);
        check("en_rel_col_n", 32'(col_n), 32'hF);
        check("en_rel_held", 32'(key_held), 32'h0);
        check("en_rel_valid", 32'(key_valid), 32'h0);
        check("en_rel_code", 32'(key_code), 32'h9);
        pressed = '0;
        step(3);
        en = 1'b1;
        step(10);

        for (int it = 0; it < 60; it++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                en = 1'b0;
                step($urandom_range(1, 4));
                en = 1'b1;
            end else if (kind == 1) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end else begin
                pressed = 16'(1) << $urandom_range(0, 15);
                if (kind == 2) pressed = pressed | (16'(1) << $urandom_range(0, 15));
                step($urandom_range(3, 60));
                if ($urandom_range(0, 3) == 0) begin
                    bounce = 4'($urandom_range(0, 15));
                    step($urandom_range(1, 3));
                    bounce = 4'b0000;
                    step($urandom_range(1, 30));
                end
                pressed = '0;
                step($urandom_range(2, 40));
            end
        end
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
